// File: rtl/mem_router.sv
// rtl/mem_router.sv - parametrised single-master, N-slave memory-bus router
//
// Decodes each master request against a table of base/mask windows and forwards
// it, rebased to the window offset, to the lowest-indexed matching slave. While a
// transaction is outstanding only the selected slave's response is returned.
// One further request can wait in a pending buffer. Unmapped addresses and
// transactions that exceed TIMEOUT busy cycles are answered with an error.
//
// Ports:
//   clock, reset        system clock, asynchronous active-low reset
//   m_valid/m_instr/m_addr/m_wdata/m_wstrb   master request (wstrb==0 is a read)
//   m_rdata/m_ready/m_error                  master response, m_ready is a 1-cycle strobe
//   s_valid[NUM_SLAVES]                      per-slave request strobe
//   s_instr/s_addr/s_wdata/s_wstrb           broadcast request (s_addr is the slave offset)
//   s_rdata/s_ready/s_error                  per-slave responses, packed by slave index
//   busy                                     transaction outstanding or request pending
//   overflow                                 sticky: a request was dropped, buffer full
module mem_router #(
  parameter int NUM_SLAVES = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT = 1024
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           m_valid,
  input  logic                           m_instr,
  input  logic [ADDR_WIDTH-1:0]          m_addr,
  input  logic [DATA_WIDTH-1:0]          m_wdata,
  input  logic [DATA_WIDTH/8-1:0]        m_wstrb,
  output logic [DATA_WIDTH-1:0]          m_rdata,
  output logic                           m_ready,
  output logic                           m_error,
  output logic [NUM_SLAVES-1:0]          s_valid,
  output logic                           s_instr,
  output logic [ADDR_WIDTH-1:0]          s_addr,
  output logic [DATA_WIDTH-1:0]          s_wdata,
  output logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]          s_ready,
  input  logic [NUM_SLAVES-1:0]          s_error,
  output logic                           busy,
  output logic                           overflow
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int BW = DATA_WIDTH / 8;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, ERR, ISSUE} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] sel, sel_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pend_valid, pend_valid_nxt;
  logic          pend_instr, pend_instr_nxt;
  logic [AW-1:0] pend_addr, pend_addr_nxt;
  logic [DW-1:0] pend_wdata, pend_wdata_nxt;
  logic [BW-1:0] pend_wstrb, pend_wstrb_nxt;
  logic          overflow_q, overflow_nxt;

  // The request being issued this cycle: the master port in IDLE, the
  // pending register in ISSUE (which is always valid in that state).
  logic          iss_valid, iss_instr;
  logic [AW-1:0] iss_addr;
  logic [DW-1:0] iss_wdata;
  logic [BW-1:0] iss_wstrb;

  always_comb begin
    iss_valid = 1'b0;
    iss_instr = m_instr;
    iss_addr  = m_addr;
    iss_wdata = m_wdata;
    iss_wstrb = m_wstrb;
    if (state == IDLE) begin
      iss_valid = m_valid;
    end else if (state == ISSUE) begin
      iss_valid = 1'b1;
      iss_instr = pend_instr;
      iss_addr  = pend_addr;
      iss_wdata = pend_wdata;
      iss_wstrb = pend_wstrb;
    end
  end

  // Address decode; scanning from the top down leaves the lowest hit standing.
  logic          hit_any;
  logic [SW-1:0] win;
  logic [AW-1:0] win_base;

  always_comb begin
    hit_any  = 1'b0;
    win      = '0;
    win_base = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (~|(SLAVE_BASE[i*AW +: AW] ^ (iss_addr & ~SLAVE_MASK[i*AW +: AW]))) begin
        hit_any  = 1'b1;
        win      = SW'(i);
        win_base = SLAVE_BASE[i*AW +: AW];
      end
    end
  end

  // Response of the currently selected slave only.
  logic          sel_ready, sel_error;
  logic [DW-1:0] sel_rdata;

  always_comb begin
    sel_ready = 1'b0;
    sel_error = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == SW'(i)) begin
        sel_ready = s_ready[i];
        sel_error = s_error[i];
        sel_rdata = s_rdata[i*DW +: DW];
      end
    end
  end

  logic timeout_hit;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST) && !sel_ready;

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    cnt_nxt        = cnt;
    pend_valid_nxt = pend_valid;
    pend_instr_nxt = pend_instr;
    pend_addr_nxt  = pend_addr;
    pend_wdata_nxt = pend_wdata;
    pend_wstrb_nxt = pend_wstrb;
    overflow_nxt   = overflow_q;
    m_ready        = 1'b0;
    m_error        = 1'b0;
    m_rdata        = '0;
    s_valid        = '0;
    s_instr        = 1'b0;
    s_addr         = '0;
    s_wdata        = '0;
    s_wstrb        = '0;

    if (iss_valid) begin
      s_instr = iss_instr;
      s_wdata = iss_wdata;
      s_wstrb = iss_wstrb;
      s_addr  = hit_any ? (iss_addr - win_base) : iss_addr;
      if (hit_any) begin
        s_valid   = NUM_SLAVES'(1) << win;
        state_nxt = BUSY;
        sel_nxt   = win;
        cnt_nxt   = '0;
      end else begin
        state_nxt = ERR;
      end
    end

    // The ISSUE cycle empties the buffer first so a request arriving in the
    // same cycle can take its place.
    if (state == ISSUE) pend_valid_nxt = 1'b0;

    if (m_valid && (state != IDLE)) begin
      if (!pend_valid || (state == ISSUE)) begin
        pend_valid_nxt = 1'b1;
        pend_instr_nxt = m_instr;
        pend_addr_nxt  = m_addr;
        pend_wdata_nxt = m_wdata;
        pend_wstrb_nxt = m_wstrb;
      end else begin
        overflow_nxt = 1'b1;
      end
    end

    // Completion looks at the buffer after capture, so a request arriving
    // on the completion cycle goes through ISSUE rather than being lost.
    case (state)
      ERR: begin
        m_ready   = 1'b1;
        m_error   = 1'b1;
        state_nxt = pend_valid_nxt ? ISSUE : IDLE;
      end
      BUSY: begin
        m_ready = sel_ready;
        m_error = sel_error;
        m_rdata = sel_rdata;
        if (sel_ready) begin
          state_nxt = pend_valid_nxt ? ISSUE : IDLE;
        end else if (timeout_hit) begin
          m_ready   = 1'b1;
          m_error   = 1'b1;
          m_rdata   = '0;
          state_nxt = pend_valid_nxt ? ISSUE : IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: ;
    endcase

    // Combinational paths from m_*/s_* must also be silent while in reset.
    if (!reset) begin
      m_ready = 1'b0;
      m_error = 1'b0;
      m_rdata = '0;
      s_valid = '0;
      s_instr = 1'b0;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sel        <= '0;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_instr <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      pend_wstrb <= '0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      cnt        <= cnt_nxt;
      pend_valid <= pend_valid_nxt;
      pend_instr <= pend_instr_nxt;
      pend_addr  <= pend_addr_nxt;
      pend_wdata <= pend_wdata_nxt;
      pend_wstrb <= pend_wstrb_nxt;
      overflow_q <= overflow_nxt;
    end
  end

  assign busy     = (state != IDLE) | pend_valid;
  assign overflow = overflow_q;

endmodule
